bsg_fifo_1r1w_banked_multi: RTL and testbench

Parametrised banked 1-read/1-write FIFO: `num_banks_p` independent register-array banks, written and read in strict round-robin order, so global FIFO order is preserved. Each bank holds `els_p/num_banks_p` entries. Adds an occupancy count output and configurable bank count. Sits in `bsg_dataflow` as a deep elastic buffer between valid/ready producers and valid/yumi consumers.

---
 rtl/bsg_fifo_banked_pkg.sv | 24 ++
 rtl/bsg_fifo_1r1w_bank.sv | 62 ++++++
 rtl/bsg_fifo_1r1w_banked_multi.sv | 106 ++++++++++
 tb/tb_bsg_fifo_1r1w_banked_multi.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_banked_pkg.sv
// rtl/bsg_fifo_banked_pkg.sv - shared sizing helpers for the banked 1r1w FIFO
//
// Purpose: width/size helper functions shared by bsg_fifo_1r1w_banked_multi
//          and its bank sub-module.
// Ports:   none (package).
package bsg_fifo_banked_pkg;

    // Entries held by each bank.
    function automatic int bank_els_f(input int els, input int num_banks);
        return els / num_banks;
    endfunction

    // Pointer width for an n-entry ring; a single-entry ring still gets one
    // (constant-zero) bit so no zero-width vectors are ever declared.
    function automatic int ptr_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..els inclusive.
    function automatic int count_width_f(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_bank.sv
// rtl/bsg_fifo_1r1w_bank.sv - single register-array bank of the banked FIFO
//
// Purpose: one power-of-two deep register FIFO with wrap-bit full/empty.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   v_i, data_i        push (caller guarantees ~full_o)
//   yumi_i             pop  (caller guarantees ~empty_o)
//   full_o, empty_o    occupancy flags from registered pointers
//   data_o             current head entry
module bsg_fifo_1r1w_bank
    import bsg_fifo_banked_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 128
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = ptr_width_f(els_p);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_tail;
    logic [ptr_w_lp-1:0] r_head;
    logic                r_tail_wrap;
    logic                r_head_wrap;

    // The wrap bit rides as the carry-out of each pointer, so the pair counts
    // naturally through 2*els_p states.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tail      <= '0;
            r_head      <= '0;
            r_tail_wrap <= 1'b0;
            r_head_wrap <= 1'b0;
        end else begin
            if (v_i) begin
                {r_tail_wrap, r_tail} <= {r_tail_wrap, r_tail} + 1'b1;
            end
            if (yumi_i) begin
                {r_head_wrap, r_head} <= {r_head_wrap, r_head} + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            r_mem[r_tail] <= data_i;
        end
    end

    assign full_o  = (r_tail == r_head) && (r_tail_wrap != r_head_wrap);
    assign empty_o = (r_tail == r_head) && (r_tail_wrap == r_head_wrap);
    assign data_o  = r_mem[r_head];

endmodule

// File: rtl/bsg_fifo_1r1w_banked_multi.sv
// rtl/bsg_fifo_1r1w_banked_multi.sv - round-robin banked 1r1w FIFO with optional occupancy count
//
// Purpose: deep elastic buffer built from num_banks_p register banks written
//          and read in strict round-robin order, preserving global order.
// Config:  BSG_FIFO_1R1W_BANKED_MULTI_COUNT_EN builds the occupancy counter;
//          without it count_o is tied to 0.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   data_i, v_i        write side; accepted when v_i & ready_o
//   ready_o            tail bank not full (registered state only)
//   v_o, data_o        head bank not empty / head entry (registered state only)
//   yumi_i             consumer takes head; legal only with v_o
//   count_o            occupancy
module bsg_fifo_1r1w_banked_multi
    import bsg_fifo_banked_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int els_p       = 256,
    parameter int num_banks_p = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [width_p-1:0]              data_i,
    input  logic                            v_i,
    output logic                            ready_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    input  logic                            yumi_i,
    output logic [count_width_f(els_p)-1:0] count_o
);
    localparam int bank_els_lp   = bank_els_f(els_p, num_banks_p);
    localparam int bank_ptr_w_lp = ptr_width_f(num_banks_p);
    localparam int count_w_lp    = count_width_f(els_p);
    localparam logic [bank_ptr_w_lp-1:0] last_bank_lp = bank_ptr_w_lp'(num_banks_p - 1);

    logic [bank_ptr_w_lp-1:0] r_wb;
    logic [bank_ptr_w_lp-1:0] r_rb;
    logic [num_banks_p-1:0]   w_full;
    logic [num_banks_p-1:0]   w_empty;
    logic [num_banks_p-1:0]   w_bank_v;
    logic [num_banks_p-1:0]   w_bank_yumi;
    logic [width_p-1:0]       w_bank_data [num_banks_p];
    logic                     w_wr;
    logic                     w_pop;

    assign ready_o = ~w_full[r_wb];
    assign v_o     = ~w_empty[r_rb];
    assign data_o  = w_bank_data[r_rb];

    // Pop is qualified with v_o so an illegal yumi_i cannot corrupt pointers.
    assign w_wr  = v_i & ready_o;
    assign w_pop = yumi_i & v_o;

    // Single-bank builds keep the pointers pinned at 0 since last_bank_lp is 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wb <= '0;
            r_rb <= '0;
        end else begin
            if (w_wr) begin
                r_wb <= (r_wb == last_bank_lp) ? '0 : r_wb + 1'b1;
            end
            if (w_pop) begin
                r_rb <= (r_rb == last_bank_lp) ? '0 : r_rb + 1'b1;
            end
        end
    end

    for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
        assign w_bank_v[b]    = w_wr  & (r_wb == bank_ptr_w_lp'(b));
        assign w_bank_yumi[b] = w_pop & (r_rb == bank_ptr_w_lp'(b));

        bsg_fifo_1r1w_bank #(
            .width_p (width_p),
            .els_p   (bank_els_lp)
        ) u_bank (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .v_i       (w_bank_v[b]),
            .data_i    (data_i),
            .full_o    (w_full[b]),
            .empty_o   (w_empty[b]),
            .data_o    (w_bank_data[b]),
            .yumi_i    (w_bank_yumi[b])
        );
    end

`ifdef BSG_FIFO_1R1W_BANKED_MULTI_COUNT_EN
    logic [count_w_lp-1:0] r_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (w_wr && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_banked_multi.sv
// tb/tb_bsg_fifo_1r1w_banked_multi.sv - self-checking bench for bsg_fifo_1r1w_banked_multi
module tb_bsg_fifo_1r1w_banked_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Index 0: 2 banks x 4, index 1: 1 bank x 16, index 2: 4 banks x 4.
    logic       v_a   [3];
    logic       y_a   [3];
    logic [7:0] din_a [3];
    logic       rdy   [3];
    logic       vo    [3];
    logic [7:0] dout  [3];
    logic [4:0] cnt   [3];
    logic [3:0] cnt0;
    logic [4:0] cnt1;
    logic [4:0] cnt2;

    assign cnt[0] = {1'b0, cnt0};
    assign cnt[1] = cnt1;
    assign cnt[2] = cnt2;

    logic [7:0] q [3][$];

    bsg_fifo_1r1w_banked_multi #(.width_p(8), .els_p(8), .num_banks_p(2)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(din_a[0]), .v_i(v_a[0]), .ready_o(rdy[0]),
        .v_o(vo[0]), .data_o(dout[0]), .yumi_i(y_a[0]), .count_o(cnt0));
    bsg_fifo_1r1w_banked_multi #(.width_p(8), .els_p(16), .num_banks_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(din_a[1]), .v_i(v_a[1]), .ready_o(rdy[1]),
        .v_o(vo[1]), .data_o(dout[1]), .yumi_i(y_a[1]), .count_o(cnt1));
    bsg_fifo_1r1w_banked_multi #(.width_p(8), .els_p(16), .num_banks_p(4)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(din_a[2]), .v_i(v_a[2]), .ready_o(rdy[2]),
        .v_o(vo[2]), .data_o(dout[2]), .yumi_i(y_a[2]), .count_o(cnt2));

    function automatic int els_of(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int exp_count(input int d);
`ifdef BSG_FIFO_1R1W_BANKED_MULTI_COUNT_EN
        return q[d].size();
`else
        return 0;
`endif
    endfunction

    // One cycle on instance d: drive at the falling edge, check state-only
    // outputs, then apply the reference queue at the rising edge.
    task automatic step(input int d, input bit v, input bit y, input logic [7:0] din);
        bit yy;
        bit wr;
        yy = y && (q[d].size() > 0);
        v_a[d] = v;
        y_a[d] = yy;
        din_a[d] = din;
        #1;
        checks++;
        if (vo[d] !== (q[d].size() > 0)) begin
            failures++;
            $display("FAIL v_o[%0d] got=%b exp=%b", d, vo[d], q[d].size() > 0);
        end
        checks++;
        if (rdy[d] !== (q[d].size() < els_of(d))) begin
            failures++;
            $display("FAIL ready_o[%0d] got=%b exp=%b", d, rdy[d], q[d].size() < els_of(d));
        end
        checks++;
        if (int'(cnt[d]) != exp_count(d)) begin
            failures++;
            $display("FAIL count_o[%0d] got=%0d exp=%0d", d, cnt[d], exp_count(d));
        end
        if (q[d].size() > 0) begin
            checks++;
            if (dout[d] !== q[d][0]) begin
                failures++;
                $display("FAIL data_o[%0d] got=%h exp=%h", d, dout[d], q[d][0]);
            end
        end
        if (yy && !vo[d]) begin
            failures++;
            $display("FAIL yumi_legal[%0d] yumi_i with v_o=0", d);
        end
        wr = v && (q[d].size() < els_of(d));
        @(posedge clk);
        if (yy) void'(q[d].pop_front());
        if (wr) q[d].push_back(din);
        @(negedge clk);
        v_a[d] = 1'b0;
        y_a[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            v_a[d] = 1'b0; y_a[d] = 1'b0; din_a[d] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h30 + 8'(i));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vo[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_v_o got=%b exp=0", vo[0]);
        end
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_o got=%b exp=1", rdy[0]);
        end
        checks++;
        if (cnt[0] !== 5'd0) begin
            failures++;
            $display("FAIL reset_count_o got=%0d exp=0", cnt[0]);
        end
        for (int d = 0; d < 3; d++) q[d].delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 8'h5A);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i));
        step(0, 1, 0, 8'h09);
        checks++;
        if (q[0].size() != 8 || rdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL fill_full got_ready=%b exp_ready=0 model_size=%0d", rdy[0], q[0].size());
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    task automatic test_full_pop_same_cycle;
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'h10 + 8'(i));
        step(0, 1, 1, 8'hAA);
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_ready got=%b exp=1", rdy[0]);
        end
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat;
        pat = 8'h40;
        step(0, 1, 0, pat);
        for (int i = 0; i < 100; i++) begin
            pat = pat + 8'd1;
            step(0, 1, 1, pat);
        end
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    task automatic test_param_sweep;
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 400; i++) begin
                step(d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 8'($urandom));
            end
            while (q[d].size() > 0) step(d, 0, 1, 8'h00);
            step(d, 0, 0, 8'h00);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_full_pop_same_cycle;
        test_back_to_back;
        test_param_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
